// File: rtl/exc_seq_ctrl.sv
// Exception sequencer: on an exception it saves PC-4 into EPC, fetches the cause's vector byte and loads it into PC.
// Latency 5+MEM_LAT busy cycles from request edge to done; requests while busy are dropped (no queueing, no backpressure).
module exc_seq_ctrl #(
    parameter logic [31:0] VEC_OPCODE = 32'd253,
    parameter logic [31:0] VEC_OVF    = 32'd254,
    parameter logic [31:0] VEC_DIV0   = 32'd255,
    parameter int          MEM_LAT    = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        exc_opcode,
    input  logic        exc_ovf,
    input  logic        exc_div0,
    output logic        busy,
    output logic        alu_sub,
    output logic        epc_w,
    output logic        mem_addr_sel,
    output logic [31:0] vec_addr,
    output logic        pc_src_vec,
    output logic        pc_w,
    output logic        done,
    output logic [1:0]  exc_cause
);

    localparam int CNT_W = 3;

    if (MEM_LAT < 1 || MEM_LAT > 7) begin : g_bad_mem_lat
        $error("exc_seq_ctrl: MEM_LAT must be in 1..7");
    end

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_CALC = 3'd1,
        S_EPC  = 3'd2,
        S_ADDR = 3'd3,
        S_WAIT = 3'd4,
        S_LOAD = 3'd5,
        S_DONE = 3'd6
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [1:0]         cause_q, cause_d;

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            cause_q <= 2'b00;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            cause_q <= cause_d;
        end
    end

    // Next-state logic; opcode outranks overflow outranks divide-by-zero
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        cause_d = cause_q;
        unique case (state_q)
            S_IDLE: begin
                if (exc_opcode) begin
                    cause_d = 2'b01;
                    state_d = S_CALC;
                end else if (exc_ovf) begin
                    cause_d = 2'b10;
                    state_d = S_CALC;
                end else if (exc_div0) begin
                    cause_d = 2'b11;
                    state_d = S_CALC;
                end
            end
            S_CALC: state_d = S_EPC;
            S_EPC:  state_d = S_ADDR;
            S_ADDR: begin
                cnt_d   = CNT_W'(MEM_LAT - 1);
                state_d = S_WAIT;
            end
            S_WAIT: begin
                // Counter starts at MEM_LAT-1, so WAIT lasts exactly MEM_LAT cycles
                if (cnt_q == '0) begin
                    state_d = S_LOAD;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            S_LOAD: state_d = S_DONE;
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    logic [31:0] cause_vec;

    always_comb begin
        cause_vec = '0;
        unique case (cause_q)
            2'b01:   cause_vec = VEC_OPCODE;
            2'b10:   cause_vec = VEC_OVF;
            2'b11:   cause_vec = VEC_DIV0;
            default: cause_vec = '0;
        endcase
    end

    // Moore outputs decoded from the registered state
    always_comb begin
        busy         = 1'b0;
        alu_sub      = 1'b0;
        epc_w        = 1'b0;
        mem_addr_sel = 1'b0;
        pc_src_vec   = 1'b0;
        pc_w         = 1'b0;
        done         = 1'b0;
        vec_addr     = '0;
        if (state_q != S_IDLE) begin
            busy     = 1'b1;
            vec_addr = cause_vec;
        end
        unique case (state_q)
            S_CALC: alu_sub = 1'b1;
            S_EPC: begin
                alu_sub = 1'b1;
                epc_w   = 1'b1;
            end
            S_ADDR: mem_addr_sel = 1'b1;
            S_WAIT: mem_addr_sel = 1'b1;
            S_LOAD: begin
                mem_addr_sel = 1'b1;
                pc_src_vec   = 1'b1;
                pc_w         = 1'b1;
            end
            S_DONE: done = 1'b1;
            default: ;
        endcase
    end

    assign exc_cause = cause_q;

endmodule

// File: tb/tb_exc_seq_ctrl.sv
// Bench for exc_seq_ctrl: stimulus queues expected busy-cycle records, a negedge monitor pops and compares them.
module tb_exc_seq_ctrl;

    typedef struct packed {
        logic        busy;
        logic        alu_sub;
        logic        epc_w;
        logic        mem_addr_sel;
        logic [31:0] vec_addr;
        logic        pc_src_vec;
        logic        pc_w;
        logic        done;
        logic [1:0]  exc_cause;
    } out_t;

    typedef struct packed {
        out_t o;
        int   gap;
    } rec_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic opc2 = 1'b0, ovf2 = 1'b0, div2 = 1'b0;
    logic opc5 = 1'b0, ovf5 = 1'b0, div5 = 1'b0;

    logic        busy2, alu2, epcw2, mas2, pcs2, pcw2, done2;
    logic [31:0] vec2;
    logic [1:0]  cause2;
    logic        busy5, alu5, epcw5, mas5, pcs5, pcw5, done5;
    logic [31:0] vec5;
    logic [1:0]  cause5;

    out_t o2, o5;
    assign o2 = {busy2, alu2, epcw2, mas2, vec2, pcs2, pcw2, done2, cause2};
    assign o5 = {busy5, alu5, epcw5, mas5, vec5, pcs5, pcw5, done5, cause5};

    exc_seq_ctrl #(.MEM_LAT(2)) u_dut2 (
        .clk(clk), .reset(reset),
        .exc_opcode(opc2), .exc_ovf(ovf2), .exc_div0(div2),
        .busy(busy2), .alu_sub(alu2), .epc_w(epcw2), .mem_addr_sel(mas2),
        .vec_addr(vec2), .pc_src_vec(pcs2), .pc_w(pcw2), .done(done2),
        .exc_cause(cause2)
    );

    exc_seq_ctrl #(.MEM_LAT(5)) u_dut5 (
        .clk(clk), .reset(reset),
        .exc_opcode(opc5), .exc_ovf(ovf5), .exc_div0(div5),
        .busy(busy5), .alu_sub(alu5), .epc_w(epcw5), .mem_addr_sel(mas5),
        .vec_addr(vec5), .pc_src_vec(pcs5), .pc_w(pcw5), .done(done5),
        .exc_cause(cause5)
    );

    always #5 clk = ~clk;

    rec_t q2[$];
    rec_t q5[$];
    logic [1:0] exp_cause2 = 2'b00;
    logic [1:0] exp_cause5 = 2'b00;
    int   idle2 = 0, idle5 = 0;
    logic mon_en = 1'b0;
    int   tests = 0, fails = 0;

    task automatic chk_out(input string nm, input out_t act, input out_t exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s t=%0t got=%h exp=%h", nm, $time, act, exp);
        end
    endtask

    task automatic chk_int(input string nm, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s t=%0t got=%0d exp=%0d", nm, $time, act, exp);
        end
    endtask

    function automatic out_t mk(input logic alu, input logic epc, input logic mas,
                                input logic pcs, input logic pcw, input logic dn,
                                input logic [31:0] vec, input logic [1:0] cause);
        out_t r;
        r = '{busy: 1'b1, alu_sub: alu, epc_w: epc, mem_addr_sel: mas,
              vec_addr: vec, pc_src_vec: pcs, pc_w: pcw, done: dn, exc_cause: cause};
        return r;
    endfunction

    function automatic out_t idle_out(input logic [1:0] cause);
        out_t r;
        r = '0;
        r.exc_cause = cause;
        return r;
    endfunction

    // Expected per-cycle records for one sequence: CALC, EPC, ADDR, WAIT x lat, LOAD, DONE
    task automatic push_seq(input int inst, input int lat, input logic [31:0] vec,
                            input logic [1:0] cause, input int gap, input int nrec);
        rec_t seq[$];
        seq.push_back('{o: mk(1, 0, 0, 0, 0, 0, vec, cause), gap: gap});
        seq.push_back('{o: mk(1, 1, 0, 0, 0, 0, vec, cause), gap: -1});
        seq.push_back('{o: mk(0, 0, 1, 0, 0, 0, vec, cause), gap: -1});
        for (int i = 0; i < lat; i++)
            seq.push_back('{o: mk(0, 0, 1, 0, 0, 0, vec, cause), gap: -1});
        seq.push_back('{o: mk(0, 0, 1, 1, 1, 0, vec, cause), gap: -1});
        seq.push_back('{o: mk(0, 0, 0, 0, 0, 1, vec, cause), gap: -1});
        for (int i = 0; i < seq.size() && i < nrec; i++) begin
            if (inst == 5) q5.push_back(seq[i]);
            else           q2.push_back(seq[i]);
        end
    endtask

    always @(negedge clk) begin
        rec_t e;
        if (mon_en) begin
            if (busy2 === 1'b1) begin
                if (q2.size() == 0) begin
                    chk_out("unexpected_busy_lat2", o2, idle_out(exp_cause2));
                end else begin
                    e = q2.pop_front();
                    chk_out("seq_lat2", o2, e.o);
                    if (e.gap >= 0) chk_int("idle_gap_lat2", idle2, e.gap);
                end
                idle2 = 0;
            end else begin
                chk_out("idle_lat2", o2, idle_out(exp_cause2));
                idle2++;
            end
            if (busy5 === 1'b1) begin
                if (q5.size() == 0) begin
                    chk_out("unexpected_busy_lat5", o5, idle_out(exp_cause5));
                end else begin
                    e = q5.pop_front();
                    chk_out("seq_lat5", o5, e.o);
                    if (e.gap >= 0) chk_int("idle_gap_lat5", idle5, e.gap);
                end
                idle5 = 0;
            end else begin
                chk_out("idle_lat5", o5, idle_out(exp_cause5));
                idle5++;
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    initial begin
        // Reset for two edges; monitor starts once the first reset edge has landed
        tick(1);
        mon_en = 1'b1;
        tick(1);
        reset = 1'b0;
        tick(20);

        // Single-cycle overflow pulse
        ovf2 = 1'b1;
        exp_cause2 = 2'b10;
        push_seq(2, 2, 32'd254, 2'b10, -1, 99);
        tick(1);
        ovf2 = 1'b0;
        tick(12);

        // Opcode and div0 together: opcode wins, div0 is dropped
        opc2 = 1'b1;
        div2 = 1'b1;
        exp_cause2 = 2'b01;
        push_seq(2, 2, 32'd253, 2'b01, -1, 99);
        tick(1);
        opc2 = 1'b0;
        div2 = 1'b0;
        tick(14);

        // div0 held: two back-to-back sequences with one idle cycle between
        div2 = 1'b1;
        exp_cause2 = 2'b11;
        push_seq(2, 2, 32'd255, 2'b11, -1, 99);
        push_seq(2, 2, 32'd255, 2'b11, 1, 99);
        tick(15);
        div2 = 1'b0;
        tick(6);

        // Overflow sequence aborted by reset during the first WAIT cycle
        ovf2 = 1'b1;
        exp_cause2 = 2'b10;
        push_seq(2, 2, 32'd254, 2'b10, -1, 4);
        tick(1);
        ovf2 = 1'b0;
        tick(3);
        reset = 1'b1;
        exp_cause2 = 2'b00;
        exp_cause5 = 2'b00;
        tick(1);
        reset = 1'b0;
        tick(8);

        // Longer memory latency instance
        ovf5 = 1'b1;
        exp_cause5 = 2'b10;
        push_seq(5, 5, 32'd254, 2'b10, -1, 99);
        tick(1);
        ovf5 = 1'b0;
        tick(15);

        chk_int("leftover_lat2", q2.size(), 0);
        chk_int("leftover_lat5", q5.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
